// File: rtl/usb_pkg.sv
// Shared USB constants: PID bytes, packet kinds and the host transaction FSM states.
package usb_pkg;

   // PID byte is {~pid, pid}
   localparam logic [7:0] PID_OUT   = 8'hE1;
   localparam logic [7:0] PID_IN    = 8'h69;
   localparam logic [7:0] PID_DATA0 = 8'hC3;
   localparam logic [7:0] PID_ACK   = 8'hD2;
   localparam logic [7:0] PID_NAK   = 8'h5A;

   typedef enum logic [1:0] {
      KIND_TOKEN     = 2'd0,
      KIND_DATA      = 2'd1,
      KIND_HANDSHAKE = 2'd2
   } tx_kind_t;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_SEND_TOKEN = 3'd1,
      ST_SEND_DATA  = 3'd2,
      ST_WAIT_HS    = 3'd3,
      ST_WAIT_DATA  = 3'd4,
      ST_SEND_ACK   = 3'd5,
      ST_DONE       = 3'd6
   } state_t;

   function automatic logic [7:0] make_pid(input logic [3:0] i_pid);
      return {~i_pid, i_pid};
   endfunction

endpackage

// File: rtl/usb_timeout_ctr.sv
// Response wait counter: counts up from 0 while enabled, saturates at
// TIMEOUT_CYCLES-1 and flags that terminal count as expired.
module usb_timeout_ctr
   import usb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_L,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [W-1:0] TC = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] r_cnt;

   // clear has priority; hold at terminal count once reached
   always_ff @(posedge clk) begin
      if (!rst_L) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_enable && !o_expired) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_expired = (r_cnt == TC);

endmodule

// File: rtl/usb_txn_ctrl.sv
// USB host transaction controller: issues token / data / handshake packets
// for one OUT or IN transaction, waits for the device, and retries.
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | ready for a request
// SEND_TOKEN  | presenting OUT/IN token to the packet encoder
// SEND_DATA   | presenting DATA0 with the OUT payload
// WAIT_HS     | waiting for the device handshake after OUT data
// WAIT_DATA   | waiting for DATA0 from the device after IN token
// SEND_ACK    | presenting ACK for received IN data
// DONE        | one-cycle completion pulse
module usb_txn_ctrl
   import usb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int MAX_RETRY      = 8
) (
   input  logic        clk,
   input  logic        rst_L,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_dir,
   input  logic [6:0]  req_addr,
   input  logic [3:0]  req_endp,
   input  logic [63:0] req_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [1:0]  tx_kind,
   output logic [7:0]  tx_pid,
   output logic [6:0]  tx_addr,
   output logic [3:0]  tx_endp,
   output logic [63:0] tx_data,
   input  logic        rx_valid,
   input  logic [7:0]  rx_pid,
   input  logic [63:0] rx_data,
   input  logic        rx_crc_ok,
   output logic        done,
   output logic        success,
   output logic [63:0] rd_data,
   output logic        busy
);

   localparam int AW = $clog2(MAX_RETRY + 1);

   state_t      r_state;
   state_t      w_next;
   logic        r_dir;
   logic [6:0]  r_addr;
   logic [3:0]  r_endp;
   logic [63:0] r_data;
   logic [AW-1:0] r_attempt;
   logic [AW-1:0] w_attempt_nxt;
   logic        r_success;
   logic [63:0] r_rd_data;
   tx_kind_t    w_kind;
   logic        w_tx_valid;
   logic        w_fail;
   logic        w_win;
   logic        w_rd_load;
   logic        w_in_wait;
   logic        w_expired;
   logic        w_accept;

   assign w_in_wait     = (r_state == ST_WAIT_HS) || (r_state == ST_WAIT_DATA);
   assign w_accept      = req_valid && req_ready;
   assign w_attempt_nxt = r_attempt + AW'(1);

   // counter is held at 0 outside the wait states so every wait starts from 0
   usb_timeout_ctr #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk       (clk),
      .rst_L     (rst_L),
      .i_clear   (!w_in_wait),
      .i_enable  (w_in_wait && !rx_valid),
      .o_expired (w_expired)
   );

   // state register
   always_ff @(posedge clk) begin
      if (!rst_L) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // next state, packet fields and attempt outcome
   always_comb begin
      w_next     = r_state;
      w_fail     = 1'b0;
      w_win      = 1'b0;
      w_rd_load  = 1'b0;
      w_tx_valid = 1'b0;
      w_kind     = KIND_TOKEN;
      tx_pid     = 8'h00;
      tx_addr    = 7'd0;
      tx_endp    = 4'd0;
      tx_data    = 64'd0;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) w_next = ST_SEND_TOKEN;
         end
         ST_SEND_TOKEN: begin
            w_tx_valid = 1'b1;
            w_kind     = KIND_TOKEN;
            tx_pid     = r_dir ? PID_IN : PID_OUT;
            tx_addr    = r_addr;
            tx_endp    = r_endp;
            if (tx_ready) w_next = r_dir ? ST_WAIT_DATA : ST_SEND_DATA;
         end
         ST_SEND_DATA: begin
            w_tx_valid = 1'b1;
            w_kind     = KIND_DATA;
            tx_pid     = PID_DATA0;
            tx_data    = r_data;
            if (tx_ready) w_next = ST_WAIT_HS;
         end
         ST_WAIT_HS: begin
            if (rx_valid) begin
               case (rx_pid)
                  PID_ACK: begin
                     w_win  = 1'b1;
                     w_next = ST_DONE;
                  end
                  PID_NAK: w_fail = 1'b1;
                  default: w_fail = 1'b1;
               endcase
            end else if (w_expired) begin
               w_fail = 1'b1;
            end
         end
         ST_WAIT_DATA: begin
            if (rx_valid) begin
               if (rx_pid == PID_DATA0 && rx_crc_ok) begin
                  w_rd_load = 1'b1;
                  w_next    = ST_SEND_ACK;
               end else begin
                  w_fail = 1'b1;
               end
            end else if (w_expired) begin
               w_fail = 1'b1;
            end
         end
         ST_SEND_ACK: begin
            w_tx_valid = 1'b1;
            w_kind     = KIND_HANDSHAKE;
            tx_pid     = PID_ACK;
            if (tx_ready) begin
               w_win  = 1'b1;
               w_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
      if (w_fail) begin
         w_next = (w_attempt_nxt < AW'(MAX_RETRY)) ? ST_SEND_TOKEN : ST_DONE;
      end
   end

   // request latch, attempt count and result registers
   always_ff @(posedge clk) begin
      if (!rst_L) begin
         r_dir     <= 1'b0;
         r_addr    <= 7'd0;
         r_endp    <= 4'd0;
         r_data    <= 64'd0;
         r_attempt <= '0;
         r_success <= 1'b0;
         r_rd_data <= 64'd0;
      end else begin
         if (w_accept) begin
            r_dir     <= req_dir;
            r_addr    <= req_addr;
            r_endp    <= req_endp;
            r_data    <= req_data;
            r_attempt <= '0;
            r_success <= 1'b0;
            r_rd_data <= 64'd0;
         end
         if (w_fail)    r_attempt <= w_attempt_nxt;
         if (w_win)     r_success <= 1'b1;
         if (w_rd_load) r_rd_data <= rx_data;
      end
   end

   assign req_ready = (r_state == ST_IDLE) && rst_L;
   assign done      = (r_state == ST_DONE) && rst_L;
   assign tx_valid  = w_tx_valid && rst_L;
   assign tx_kind   = w_kind;
   assign busy      = (r_state != ST_IDLE);
   assign success   = r_success;
   assign rd_data   = r_rd_data;

endmodule

// File: doc/usb_txn_ctrl.md
USB_TXN_CTRL -- requirements
Module: usb_txn_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255: response wait limit in clk cycles.
REQ-002 The block SHALL have parameter MAX_RETRY, default 8: total attempts per transaction before failure.
REQ-003 The block SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-004 The block SHALL have port rst_L, input, 1: synchronous, active-low reset.
REQ-005 The block SHALL have ports req_valid/req_ready, input/output, 1/1: transaction request handshake.
REQ-006 The block SHALL have ports req_dir, req_addr, req_endp, req_data, input, 1/7/4/64: direction (0=OUT, 1=IN), device address, endpoint and OUT payload.
REQ-007 The block SHALL have ports tx_valid/tx_ready, output/input, 1/1: packet-encoder handshake.
REQ-008 The block SHALL have ports tx_kind, tx_pid, tx_addr, tx_endp, tx_data, output, 2/8/7/4/64: packet kind (TOKEN/DATA/HANDSHAKE), PID byte and fields.
REQ-009 The block SHALL have ports rx_valid, rx_pid, rx_data, rx_crc_ok, input, 1/8/64/1: decoded packet from device.
REQ-010 The block SHALL have ports done, success, rd_data, busy, output, 1/1/64/1: completion pulse, result, IN payload and activity flag.

Function
REQ-011 PID bytes SHALL be {~pid,pid}: OUT=E1, IN=69, DATA0=C3, ACK=D2, NAK=5A.
REQ-012 The FSM states SHALL be IDLE, SEND_TOKEN, SEND_DATA, WAIT_HS, WAIT_DATA, SEND_ACK, DONE.
REQ-013 req_ready SHALL be 1 only in IDLE; on req_valid&&req_ready the block latches all req_* fields, clears the attempt count and enters SEND_TOKEN.
REQ-014 tx_valid SHALL be 1 only in SEND_TOKEN/SEND_DATA/SEND_ACK, with tx_* fields held stable until tx_ready; the state advances on the cycle tx_valid&&tx_ready.
REQ-015 SEND_TOKEN SHALL drive TOKEN with the OUT or IN PID and the latched addr/endp, then go to SEND_DATA (OUT) or WAIT_DATA (IN).
REQ-016 SEND_DATA SHALL drive DATA, DATA0, latched req_data, then go to WAIT_HS.
REQ-017 On entry to WAIT_HS/WAIT_DATA the wait counter SHALL clear to 0 and increment each cycle without rx_valid; reaching TIMEOUT_CYCLES-1 without rx_valid is a timeout event.
REQ-018 rx_valid in the same cycle as the timeout SHALL be processed as a response; the timeout is ignored.
REQ-019 In WAIT_HS, rx_pid=ACK SHALL go to DONE with success=1; NAK, any other PID, or timeout is a failed attempt.
REQ-020 In WAIT_DATA, rx_pid=DATA0 with rx_crc_ok=1 SHALL latch rx_data into rd_data and go to SEND_ACK; NAK, bad CRC (no handshake sent), other PID, or timeout is a failed attempt.
REQ-021 SEND_ACK SHALL drive HANDSHAKE, ACK, then go to DONE with success=1.
REQ-022 A failed attempt SHALL increment the attempt count and return to SEND_TOKEN if count<MAX_RETRY, else go to DONE with success=0.
REQ-023 DONE SHALL assert done for exactly one cycle, then return to IDLE; success/rd_data SHALL hold until the next accepted request.
REQ-024 busy SHALL equal (state!=IDLE).
REQ-025 rx_valid in any state other than WAIT_HS/WAIT_DATA SHALL be ignored.

Reset
REQ-026 With rst_L=0 at posedge, the block SHALL enter IDLE, clear all counters, drive done=0, success=0, rd_data=0, tx_valid=0, busy=0 and req_ready=0 during reset; reset mid-transaction SHALL abort it without a done pulse.

Structure
REQ-027 The PID constants, the tx_kind enum and the state enum SHALL live in shared package usb_pkg.
REQ-028 The wait counter SHALL be the sub-module usb_timeout_ctr (clear, enable, expired), reused by the device side.

Verification
REQ-029 OUT addr=2A endp=4 data=DEADBEEF_CAFEF00D, device ACK after 10 cycles -> tokens E1, C3 sent, done with success=1, 1 attempt.
REQ-030 IN endp=4, device returns DATA0 0123456789ABCDEF crc_ok -> ACK D2 sent, rd_data=0123456789ABCDEF, success=1.
REQ-031 OUT answered NAK twice then ACK -> 3 token/data pairs, success=1.
REQ-032 IN with no response, TIMEOUT_CYCLES=16, MAX_RETRY=3 -> 3 tokens, done at about 3x16 cycles plus tx overhead, success=0.
REQ-033 IN DATA0 with crc_ok=0 then a good DATA0 -> no ACK after the first, ACK after the second, success=1.
REQ-034 rst_L=0 asserted in WAIT_HS -> IDLE next cycle, no done pulse, req_ready=1 after release.
